// File: rtl/cpu_pkg.sv
// cpu_pkg: shared front-end types, jump codes and reset vector for the pipelined CPU.
package cpu_pkg;
  typedef enum logic [1:0] {RUN, BWAIT, RESOLVE} if_state_t;
  localparam logic [1:0] JMP_NONE = 2'b00;
  localparam logic [1:0] JMP_J = 2'b01;
  localparam logic [1:0] JMP_JR = 2'b10;
  localparam logic [29:0] PC_RESET_WORD = 30'h0000_0C00;
endpackage

// File: rtl/npc_sel.sv
// npc_sel: next fetch address mux with sequential, branch and jump adders (word addresses).
module npc_sel import cpu_pkg::*; (
  input  logic        hold_i,
  input  logic [29:0] pc_i,
  input  logic [29:0] b_pc_i,
  input  logic [29:0] jr_target_i,
  input  logic [1:0]  jump_i,
  input  logic        br_take_i,
  input  logic [15:0] imm16_i,
  input  logic [25:0] imm26_i,
  output logic [29:0] npc_o
);
  always_comb
    npc_o = hold_i ? pc_i :
            jump_i == JMP_J ? {b_pc_i[29:26], imm26_i} :
            jump_i[1] ? jr_target_i :
            br_take_i ? b_pc_i + {{14{imm16_i[15]}}, imm16_i} :
            pc_i + 30'd1;
endmodule

// File: rtl/if_pc_unit.sv
// if_pc_unit: program counter, next-PC selection and dependent-branch bubble FSM.
module if_pc_unit import cpu_pkg::*; #(
  parameter logic [29:0] RESET_PC = PC_RESET_WORD,
  parameter int          BR_WAIT  = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        hazard,
  input  logic        Is_branch,
  input  logic        Br_dep,
  input  logic        Branch_ok,
  input  logic [1:0]  ID_Jump,
  input  logic [31:2] ID_B_PC,
  input  logic [15:0] ID_imm16,
  input  logic [25:0] ID_imm26,
  input  logic [31:2] Jr_target,
  output logic [31:2] PC,
  output logic [31:2] B_PC,
  output logic        BranchBubble,
  output logic        Redirect
);
  localparam logic [2:0] WAIT_INIT = 3'(BR_WAIT - 1);
  if_state_t   state_q;
  logic [2:0]  cnt_q;
  logic [29:0] pc_q, pc_d;
  logic        dep_branch, br_take, decide;
  // combinational outputs are gated by reset so they read 0 while Reset is low
  always_comb begin
    dep_branch   = Is_branch && Br_dep;
    br_take      = Is_branch && Branch_ok;
    BranchBubble = Reset && (state_q == BWAIT || (state_q == RUN && !hazard && dep_branch));
    decide       = Reset && !hazard && (state_q == RESOLVE || (state_q == RUN && !dep_branch));
    Redirect     = decide && (ID_Jump != JMP_NONE || br_take);
  end
  npc_sel u_npc (
    .hold_i      (!decide),
    .pc_i        (pc_q),
    .b_pc_i      (ID_B_PC),
    .jr_target_i (Jr_target),
    .jump_i      (ID_Jump),
    .br_take_i   (br_take),
    .imm16_i     (ID_imm16),
    .imm26_i     (ID_imm26),
    .npc_o       (pc_d)
  );
  assign PC   = pc_q;
  assign B_PC = pc_q + 30'd1;
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      pc_q    <= RESET_PC;
    end else begin
      pc_q <= pc_d;
      if (!hazard)
        case (state_q)
          RUN:     if (dep_branch) begin
                     state_q <= BWAIT;
                     cnt_q   <= WAIT_INIT;
                   end
          BWAIT:   if (cnt_q == 3'd0) state_q <= RESOLVE;
                   else cnt_q <= cnt_q - 3'd1;
          RESOLVE: state_q <= RUN;
          default: state_q <= RUN;
        endcase
    end
endmodule

// File: tb/tb_if_pc_unit.sv
// tb_if_pc_unit: scoreboard bench with a cycle-level behavioural model of the fetch front end.
module tb_if_pc_unit;
  localparam int BRW = 2;
  logic        Clk = 0, Reset = 1, hazard = 0, Is_branch = 0, Br_dep = 0, Branch_ok = 0;
  logic [1:0]  ID_Jump = 0;
  logic [31:2] ID_B_PC = 0, Jr_target = 0;
  logic [15:0] ID_imm16 = 0;
  logic [25:0] ID_imm26 = 0;
  logic [31:2] PC, B_PC;
  logic        BranchBubble, Redirect;
  typedef struct {
    logic [29:0] pc;
    logic        bub;
    logic        red;
  } exp_t;
  exp_t        sb[$];
  int          vecs = 0, errs = 0;
  logic [29:0] m_pc = 30'h0C00;
  int          m_pend = -1;

  if_pc_unit #(.BR_WAIT(BRW)) dut (
    .Clk(Clk), .Reset(Reset), .hazard(hazard), .Is_branch(Is_branch), .Br_dep(Br_dep),
    .Branch_ok(Branch_ok), .ID_Jump(ID_Jump), .ID_B_PC(ID_B_PC), .ID_imm16(ID_imm16),
    .ID_imm26(ID_imm26), .Jr_target(Jr_target), .PC(PC), .B_PC(B_PC),
    .BranchBubble(BranchBubble), .Redirect(Redirect)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [29:0] act, input logic [29:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // m_pend: -1 idle, otherwise non-stalled cycles left before the decide cycle
  task automatic step(input logic hz, ib, bd, bok, input logic [1:0] jmp,
                      input logic [29:0] bpc, input logic [15:0] i16,
                      input logic [25:0] i26, input logic [29:0] jrt);
    logic dep_new, bub, dec, red;
    exp_t e;
    @(negedge Clk);
    Reset = 1; hazard = hz; Is_branch = ib; Br_dep = bd; Branch_ok = bok;
    ID_Jump = jmp; ID_B_PC = bpc; ID_imm16 = i16; ID_imm26 = i26; Jr_target = jrt;
    dep_new = m_pend < 0 && !hz && ib && bd;
    bub = m_pend > 0 || dep_new;
    dec = !hz && !bub;
    red = dec && (jmp != 2'b00 || (ib && bok));
    e.pc = m_pc; e.bub = bub; e.red = red;
    sb.push_back(e);
    if (dec)
      m_pc = jmp == 2'b01 ? {bpc[29:26], i26} : jmp[1] ? jrt :
             (ib && bok) ? bpc + 30'($signed(i16)) : m_pc + 30'd1;
    if (!hz) m_pend = dep_new ? BRW : m_pend > 0 ? m_pend - 1 : -1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 2'b00, 30'h0, 16'h0, 26'h0, 30'h0);
  endtask

  always begin : mon
    exp_t e;
    @(negedge Clk);
    #2;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("PC", PC, e.pc);
      chk("B_PC", B_PC, e.pc + 30'd1);
      chk("BranchBubble", 30'(BranchBubble), 30'(e.bub));
      chk("Redirect", 30'(Redirect), 30'(e.red));
      chk("bubble_and_redirect", 30'(BranchBubble && Redirect), 30'd0);
    end
  end

  initial begin
    Is_branch = 1; Br_dep = 1; ID_Jump = 2'b01;
    #1 Reset = 0;
    #2;
    chk("reset_PC", PC, 30'h0C00);
    chk("reset_B_PC", B_PC, 30'h0C01);
    chk("reset_bubble", 30'(BranchBubble), 30'd0);
    chk("reset_redirect", 30'(Redirect), 30'd0);
    idle(3);
    step(0, 0, 0, 0, 2'b01, 30'h0C05, 16'h0, 26'h0000100, 30'h0);
    step(0, 0, 0, 0, 2'b10, 30'h0, 16'h0, 26'h0, 30'h0C40);
    step(0, 1, 0, 1, 2'b00, 30'h0C10, 16'hFFFC, 26'h0, 30'h0);
    step(0, 1, 0, 1, 2'b00, 30'h0C10, 16'h0003, 26'h0, 30'h0);
    repeat (4) step(0, 1, 1, 1, 2'b00, 30'h0C20, 16'h0010, 26'h0, 30'h0);
    idle(1);
    repeat (2) step(0, 1, 1, 1, 2'b00, 30'h0C40, 16'h0008, 26'h0, 30'h0);
    repeat (2) step(1, 1, 1, 1, 2'b00, 30'h0C40, 16'h0008, 26'h0, 30'h0);
    repeat (2) step(0, 1, 1, 1, 2'b00, 30'h0C40, 16'h0008, 26'h0, 30'h0);
    idle(1);
    step(1, 0, 0, 0, 2'b01, 30'h0C05, 16'h0, 26'h0000200, 30'h0);
    idle(1);
    repeat (2) step(0, 1, 1, 1, 2'b00, 30'h0D00, 16'h0004, 26'h0, 30'h0);
    #3 Reset = 0;
    #1;
    chk("async_reset_PC", PC, 30'h0C00);
    chk("async_reset_bubble", 30'(BranchBubble), 30'd0);
    m_pc = 30'h0C00;
    m_pend = -1;
    idle(2);
    step(0, 0, 0, 0, 2'b10, 30'h0, 16'h0, 26'h0, 30'h3FFF_FFFF);
    idle(2);
    repeat (400) begin
      int r;
      logic [1:0] j;
      r = $urandom_range(0, 9);
      j = r == 0 ? 2'b01 : r == 1 ? 2'b10 : r == 2 ? 2'b11 : 2'b00;
      step($urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, j, 30'($urandom), 16'($urandom), 26'($urandom),
           30'($urandom));
    end
    for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge Clk);
    #3;
    vecs++;
    if (sb.size() != 0) begin
      errs++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
